parity_rr_scheduler: RTL
========================

Name: parity_rr_scheduler

Overview:
Shares the single combinational parity_checker (28-bit word in, 1-bit parity_out) between NUM_CH optical receive channels. Round-robin arbitration selects one channel's word, which is registered into the checker. The block returns the 27-bit payload, an error flag and the source channel on a valid/ready output port. Sits between the per-channel word assemblers and the frame buffer on fpga2.

Parameters:
NUM_CH, 2, number of requesting receive channels (2..8)
CNT_W, 16, width of each per-channel error counter (used only with the optional feature)
WORD_W, 28, checked word width; fixed to match parity_checker, not to be overridden

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
ch_data_in  in  NUM_CH*WORD_W  channel i word at [i*28 +: 28]; bit 0 is the parity bit, bits 27:1 are payload
ch_valid_in  in  NUM_CH  channel word valid
ch_ready_out  out  NUM_CH  one-hot accept; a word is taken when valid&&ready
out_data  out  27  payload of the checked word (word[27:1])
out_ch  out  $clog2(NUM_CH)  source channel index
out_err  out  1  1 = parity error
out_valid  out  1  result valid
out_ready  in  1  downstream accept
busy_out  out  1  high whenever state != IDLE
clr_counts_in  in  1  synchronous clear of error counters (only with macro)
err_count_out  out  NUM_CH*CNT_W  per-channel error counts (only with macro)

Behaviour:
- Scheme: odd parity; a good word has odd weight. parity_checker drives parity_out=0 for odd weight and 1 for even weight, so out_err = parity_out.
- Reset state (rst low, async): state=IDLE, last_grant=NUM_CH-1 (ch0 wins first), all outputs 0, word/ch registers 0, counters 0.
- FSM IDLE:
  - Search from last_grant+1 with wrap, select the first channel with valid set.
  - ch_ready_out[grant]=1, combinational in IDLE only.
  - On the handshake, capture word_reg and ch_reg, set last_grant=grant, go to CHECK.
  - No valid: stay in IDLE, ch_ready_out=0.
- FSM CHECK: word_reg drives parity_checker. Register out_data=word_reg[27:1], out_ch=ch_reg, out_err=parity_out, out_valid=1. Go to OUTPUT.
- FSM OUTPUT: hold all out_* stable while out_ready is low. On out_valid&&out_ready, clear out_valid and go to IDLE.
- Latency: handshake in cycle N gives out_valid in cycle N+2. Throughput is at most 1 word per 3 cycles when out_ready is held high.
- ch_ready_out is 0 in CHECK and OUTPUT; requesters must hold their word until accepted.
- Simultaneous requests: round-robin only; no channel is granted twice while another is waiting.
- A requester dropping valid before grant is legal; it is simply skipped.
- Reset mid-operation aborts the word in flight with no output. Arbitration restarts at ch0.

Optional Feature:
Macro PARITY_ERR_CNT_EN.
- Defined:
  - One CNT_W counter per channel, incremented in the CHECK cycle when parity_out=1.
  - Counters saturate at all-ones and never wrap.
  - clr_counts_in=1 zeros all counters synchronously; clear wins over a same-cycle increment.
  - err_count_out shows the counter registers.
- Undefined: no counters. err_count_out is tied to 0 and clr_counts_in is ignored.

Decomposition:
- Package parity_sched_pkg holds:
  - WORD_W=28 and PAYLOAD_W=27 constants.
  - typedef enum logic [1:0] {IDLE, CHECK, OUTPUT} sched_state_t.
- Sub-module rr_arbiter (NUM_CH param) takes req and last_grant and returns a one-hot grant plus index.
- parity_checker is instantiated once, unmodified.

Test Plan:
- Good word: ch0 word 28'h0000001 (weight 1), out_ready=1 → ch_ready_out=2'b01 in cycle N; in cycle N+2 out_valid=1, out_err=0, out_ch=0, out_data=27'h0000000.
- Bad word: ch1 word 28'h0000003 (weight 2) → out_err=1, out_ch=1, out_data=27'h0000001. Word 28'hFFFFFFE (weight 27) → out_err=0.
- Fairness: after reset, ch0 and ch1 both hold valid for 4 words each → out_ch sequence is 0,1,0,1,0,1,0,1.
- Backpressure: out_ready=0 for 5 cycles with a result pending → out_* stable, out_valid=1, ch_ready_out=0 throughout; the result is accepted in the first cycle out_ready=1, then the FSM returns to IDLE.
- Reset abort: assert rst low during CHECK → out_valid=0 and busy_out=0 immediately; after release the pending ch1 request is served only after ch0 if both are valid.
- With PARITY_ERR_CNT_EN and CNT_W=2: 5 even-weight words on ch0 → err_count ch0=3 (saturated), ch1=0. Pulse clr_counts_in in the same cycle as an increment → count=0.

Source files
------------

// File: rtl/parity_sched_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// parity_sched_pkg : shared word widths and scheduler FSM state type
// Rev 1.0
// ----------------------------------------------------------------------------
package parity_sched_pkg;
  localparam int WORD_W    = 28;
  localparam int PAYLOAD_W = 27;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    OUTPUT = 2'd2
  } sched_state_t;
endpackage
`default_nettype wire

// File: rtl/parity_checker.sv
`default_nettype none
// ----------------------------------------------------------------------------
// parity_checker : combinational odd-parity check, parity_out=1 on even weight
// Rev 1.0
// ----------------------------------------------------------------------------
module parity_checker (
  input  logic [27:0] data_in,
  output logic        parity_out
);
  assign parity_out = ~(^data_in);
endmodule
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_arbiter : round-robin pick of the first requester after last_grant
// Rev 1.0
// ----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_CH = 2
) (
  input  logic [NUM_CH-1:0]         req,
  input  logic [$clog2(NUM_CH)-1:0] last_grant,
  output logic [NUM_CH-1:0]         grant,
  output logic [$clog2(NUM_CH)-1:0] grant_idx,
  output logic                      grant_vld
);
  localparam int IDX_W = $clog2(NUM_CH);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    // Offset NUM_CH wraps back to last_grant itself, so it is only picked when alone.
    for (int off = 1; off <= NUM_CH; off++) begin
      if (!grant_vld && req[(int'(last_grant) + off) % NUM_CH]) begin
        grant_vld = 1'b1;
        grant_idx = IDX_W'((int'(last_grant) + off) % NUM_CH);
      end
    end
    if (grant_vld) grant[grant_idx] = 1'b1;
  end
endmodule
`default_nettype wire

// File: rtl/parity_rr_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// parity_rr_scheduler : shares one parity_checker among NUM_CH receive channels.
// Optional per-channel error counters with macro PARITY_ERR_CNT_EN.  Rev 1.0
// ----------------------------------------------------------------------------
module parity_rr_scheduler
  import parity_sched_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH*WORD_W-1:0]   ch_data_in,
  input  logic [NUM_CH-1:0]          ch_valid_in,
  output logic [NUM_CH-1:0]          ch_ready_out,
  output logic [PAYLOAD_W-1:0]       out_data,
  output logic [$clog2(NUM_CH)-1:0]  out_ch,
  output logic                       out_err,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy_out,
  input  logic                       clr_counts_in,
  output logic [NUM_CH*CNT_W-1:0]    err_count_out
);
  localparam int IDX_W = $clog2(NUM_CH);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_CH - 1);

  sched_state_t          state_q, state_d;
  logic [IDX_W-1:0]      last_grant_q, last_grant_d;
  logic [WORD_W-1:0]     word_q, word_d;
  logic [IDX_W-1:0]      ch_q, ch_d;
  logic [PAYLOAD_W-1:0]  out_data_q, out_data_d;
  logic [IDX_W-1:0]      out_ch_q, out_ch_d;
  logic                  out_err_q, out_err_d;
  logic                  out_valid_q, out_valid_d;

  logic [NUM_CH-1:0]     grant;
  logic [IDX_W-1:0]      grant_idx;
  logic                  grant_vld;
  logic                  parity_out;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req        (ch_valid_in),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_vld  (grant_vld)
  );

  parity_checker u_chk (
    .data_in    (word_q),
    .parity_out (parity_out)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    word_d       = word_q;
    ch_d         = ch_q;
    out_data_d   = out_data_q;
    out_ch_d     = out_ch_q;
    out_err_d    = out_err_q;
    out_valid_d  = out_valid_q;
    ch_ready_out = '0;
    case (state_q)
      IDLE: begin
        // The grant only ever points at a valid channel, so ready implies handshake.
        if (grant_vld) begin
          ch_ready_out = grant;
          word_d       = ch_data_in[int'(grant_idx)*WORD_W +: WORD_W];
          ch_d         = grant_idx;
          last_grant_d = grant_idx;
          state_d      = CHECK;
        end
      end
      CHECK: begin
        out_data_d  = word_q[WORD_W-1:1];
        out_ch_d    = ch_q;
        out_err_d   = parity_out;
        out_valid_d = 1'b1;
        state_d     = OUTPUT;
      end
      OUTPUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= LAST_RST;
      word_q       <= '0;
      ch_q         <= '0;
      out_data_q   <= '0;
      out_ch_q     <= '0;
      out_err_q    <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      word_q       <= word_d;
      ch_q         <= ch_d;
      out_data_q   <= out_data_d;
      out_ch_q     <= out_ch_d;
      out_err_q    <= out_err_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_err   = out_err_q;
  assign out_valid = out_valid_q;
  assign busy_out  = (state_q != IDLE);

`ifdef PARITY_ERR_CNT_EN
  for (genvar i = 0; i < NUM_CH; i++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Clear has priority; counting stops at all-ones.
    always_comb begin
      cnt_d = cnt_q;
      if (clr_counts_in) begin
        cnt_d = '0;
      end else if ((state_q == CHECK) && parity_out && (ch_q == IDX_W'(i)) && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
    end

    assign err_count_out[i*CNT_W +: CNT_W] = cnt_q;
  end
`else
  logic unused_clr;
  assign unused_clr    = clr_counts_in;
  assign err_count_out = '0;
`endif
endmodule
`default_nettype wire
